// File: rtl/mod_frame_scheduler_pkg.sv
// Shared types and helpers for the frame scheduler that feeds the BPSK/QPSK modulator.
package mod_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_GAP
  } state_e;

  localparam logic [7:0] DEFAULT_PREAMBLE = 8'hA5;

  // Wraps a requester index that has run at most one lap past n.
  function automatic int wrapIdx(input int a, input int n);
    return (a >= n) ? a - n : a;
  endfunction

endpackage

// File: rtl/mod_frame_scheduler_if.sv
// Requester byte streams in, modulator drive and status out.
interface mod_frame_scheduler_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 mod_data;
  logic                 mod_enable;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 underrun;

  modport master (
    output req_valid, req_data, req_last,
    input  req_ready, mod_data, mod_enable, grant_id, busy, underrun
  );

  modport slave (
    input  req_valid, req_data, req_last,
    output req_ready, mod_data, mod_enable, grant_id, busy, underrun
  );
endinterface

// File: rtl/mod_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requester index at or after the pointer, wrapping.
module rr_arbiter
  import mod_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [1:0]         idx_o
);
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req_i[k] && (k == wrapIdx(int'(ptr_i) + i, NUM_REQ))) begin
          found      = 1'b1;
          grant_o[k] = 1'b1;
          idx_o      = 2'(k);
        end
      end
    end
  end

endmodule

// File: rtl/mod_frame_scheduler.sv
// Arbitrates requester byte streams and serialises preamble + payload MSB-first to the modulator.
module mod_frame_scheduler
  import mod_sched_pkg::*;
#(
  parameter int         NUM_REQ  = 2,
  parameter int         SYM_DIV  = 4,
  parameter logic [7:0] PREAMBLE = DEFAULT_PREAMBLE,
  parameter int         GAP_BITS = 2
) (
  input logic                  clk_i,
  input logic                  rst_i,
  mod_frame_scheduler_if.slave bus_io
);
  localparam int TW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam int CW = (GAP_BITS > 8) ? $clog2(GAP_BITS) : 3;
  localparam logic [TW-1:0] TIMER_MAX = TW'(SYM_DIV - 1);
  localparam logic [CW-1:0] BYTE_LAST = CW'(7);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_BITS - 1);

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [CW-1:0]      bitCnt_q, bitCnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               last_q, last_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         rrPtr_q, rrPtr_d;
  logic               enable_q, enable_d;
  logic [NUM_REQ-1:0] arbGrant;
  logic [1:0]         arbIdx;
  logic               grantValid, grantLast;
  logic [7:0]         grantData;
  logic               boundary, load, underrun;
  logic [NUM_REQ-1:0] readyVec;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (bus_io.req_valid),
    .ptr_i   (rrPtr_q),
    .grant_o (arbGrant),
    .idx_o   (arbIdx)
  );

  always_comb begin
    grantValid = 1'b0;
    grantLast  = 1'b0;
    grantData  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 2'(i)) begin
        grantValid = bus_io.req_valid[i];
        grantLast  = bus_io.req_last[i];
        grantData  = bus_io.req_data[i*8 +: 8];
      end
    end
  end

  // Shift register is cleared on leaving a frame so mod_data idles low straight from the flop.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    last_d   = last_q;
    grant_d  = grant_q;
    rrPtr_d  = rrPtr_q;
    load     = 1'b0;
    underrun = 1'b0;
    boundary = (timer_q == TIMER_MAX);

    if (state_q != ST_IDLE) begin
      timer_d = boundary ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (|arbGrant) begin
          state_d  = ST_PREAMBLE;
          grant_d  = arbIdx;
          shift_d  = PREAMBLE;
          timer_d  = '0;
          bitCnt_d = '0;
        end
      end
      ST_PREAMBLE, ST_PAYLOAD: begin
        if (boundary) begin
          if (bitCnt_q != BYTE_LAST) begin
            bitCnt_d = bitCnt_q + CW'(1);
            shift_d  = {shift_q[6:0], 1'b0};
          end else begin
            bitCnt_d = '0;
            if (state_q == ST_PAYLOAD && last_q) begin
              state_d = ST_GAP;
              shift_d = '0;
            end else if (grantValid) begin
              load    = 1'b1;
              shift_d = grantData;
              last_d  = grantLast;
              state_d = ST_PAYLOAD;
            end else begin
              underrun = 1'b1;
              state_d  = ST_GAP;
              shift_d  = '0;
            end
          end
        end
      end
      ST_GAP: begin
        if (boundary) begin
          if (bitCnt_q == GAP_LAST) begin
            state_d  = ST_IDLE;
            bitCnt_d = '0;
            rrPtr_d  = (grant_q == 2'(NUM_REQ - 1)) ? 2'd0 : grant_q + 2'd1;
          end else begin
            bitCnt_d = bitCnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    enable_d = (state_d == ST_PREAMBLE) || (state_d == ST_PAYLOAD);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      last_q   <= 1'b0;
      grant_q  <= '0;
      rrPtr_q  <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      rrPtr_q  <= rrPtr_d;
      enable_q <= enable_d;
    end
  end

  // ready/underrun answer the live valid in the boundary cycle itself, as the handshake needs.
  always_comb begin
    readyVec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      readyVec[i] = load && (grant_q == 2'(i));
    end
  end

  assign bus_io.req_ready  = readyVec;
  assign bus_io.underrun   = underrun;
  assign bus_io.mod_data   = shift_q[7];
  assign bus_io.mod_enable = enable_q;
  assign bus_io.grant_id   = grant_q;
  assign bus_io.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mod_frame_scheduler.sv
// Bench for mod_frame_scheduler: frame-level reference model checked every cycle plus literal pins.
module tb_mod_frame_scheduler;
  import mod_sched_pkg::*;

  localparam int         NUM_REQ  = 2;
  localparam int         SYM_DIV  = 2;
  localparam int         GAP_BITS = 2;
  localparam logic [7:0] PRE      = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_frame_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  mod_frame_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .SYM_DIV  (SYM_DIV),
    .PREAMBLE (PRE),
    .GAP_BITS (GAP_BITS)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int errors = 0;
  int checks = 0;

  // Requester queues hold {last, data}; forceValid raises both valids with no payload behind them.
  logic [8:0]         reqQ0[$];
  logic [8:0]         reqQ1[$];
  bit                 forceValid = 1'b1;
  logic [NUM_REQ-1:0] xfer = '0;

  int         enCount, rdyCnt0, rdyCnt1, undCnt, nStream;
  logic [63:0] stream;
  int         grantLog[$];
  int         rdyPos[$];
  int         undPos[$];
  bit         prevBusy = 1'b0;

  int  mPhase = 0;
  int  mCyc   = 0;
  int  mGrant = 0;
  int  mPtr   = 0;
  bit  mLast  = 1'b0;
  bit  mBits[$];
  logic       eData, eEn, eBusy, eUnder;
  logic [1:0] eReady, eGrant;
  logic [7:0] mByte;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int logAt(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return 0;
  endfunction

  task automatic appendByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) mBits.push_back(b[i]);
  endtask

  task automatic driveReq();
    bus.req_valid[0] = forceValid || (reqQ0.size() > 0);
    bus.req_valid[1] = forceValid || (reqQ1.size() > 0);
    bus.req_data[7:0]  = (reqQ0.size() > 0) ? reqQ0[0][7:0] : 8'h00;
    bus.req_data[15:8] = (reqQ1.size() > 0) ? reqQ1[0][7:0] : 8'h00;
    bus.req_last[0] = (reqQ0.size() > 0) ? reqQ0[0][8] : 1'b0;
    bus.req_last[1] = (reqQ1.size() > 0) ? reqQ1[0][8] : 1'b0;
  endtask

  task automatic applyStimulus(input int who, input logic last, input logic [7:0] data);
    if (who == 0) reqQ0.push_back({last, data});
    else          reqQ1.push_back({last, data});
    driveReq();
  endtask

  task automatic clearMon();
    enCount = 0; rdyCnt0 = 0; rdyCnt1 = 0; undCnt = 0; nStream = 0; stream = '0;
    grantLog.delete(); rdyPos.delete(); undPos.delete();
  endtask

  task automatic waitFrames(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (!(grantLog.size() >= n && !bus.busy) && c < budget) begin
      @(posedge clk); #2;
      c++;
    end
    checkOutput(name, 64'(grantLog.size() >= n && !bus.busy), 64'd1);
  endtask

  // Requesters pop a byte one step after the posedge at which it was transferred.
  initial begin
    driveReq();
    forever begin
      @(posedge clk); #1;
      if (xfer[0] && reqQ0.size() > 0) void'(reqQ0.pop_front());
      if (xfer[1] && reqQ1.size() > 0) void'(reqQ1.pop_front());
      driveReq();
    end
  end

  // Each falling edge: log literal observables, compare against the model, then advance the model.
  always @(negedge clk) begin
    if (bus.busy && !prevBusy) grantLog.push_back(int'(bus.grant_id));
    prevBusy = bus.busy;
    if (bus.req_ready[0]) rdyCnt0++;
    if (bus.req_ready[1]) rdyCnt1++;
    if (bus.req_ready != '0) rdyPos.push_back(enCount);
    if (bus.underrun) begin undCnt++; undPos.push_back(enCount); end
    if (bus.mod_enable) begin
      if ((enCount % SYM_DIV) == 0 && nStream < 64) begin
        stream = {stream[62:0], bus.mod_data};
        nStream++;
      end
      enCount++;
    end
    xfer = bus.req_valid & bus.req_ready;

    eEn    = (mPhase == 1);
    eBusy  = (mPhase != 0);
    eGrant = 2'(mGrant);
    eData  = (mPhase == 1) ? mBits[mCyc / SYM_DIV] : 1'b0;
    eReady = '0;
    eUnder = 1'b0;

    if (mPhase == 0) begin
      if (|bus.req_valid) begin
        mGrant = pick(bus.req_valid, mPtr);
        mPhase = 1; mCyc = 0; mLast = 1'b0;
        mBits.delete();
        appendByte(PRE);
      end
    end else if (mPhase == 1) begin
      if (((mCyc + 1) % (8 * SYM_DIV)) == 0) begin
        if ((mCyc + 1) > 8 * SYM_DIV && mLast) begin
          mPhase = 2; mCyc = 0;
        end else if (bus.req_valid[mGrant]) begin
          eReady[mGrant] = 1'b1;
          mByte = (mGrant == 0) ? bus.req_data[7:0] : bus.req_data[15:8];
          appendByte(mByte);
          mLast = bus.req_last[mGrant];
          mCyc++;
        end else begin
          eUnder = 1'b1;
          mPhase = 2; mCyc = 0;
        end
      end else begin
        mCyc++;
      end
    end else begin
      if (mCyc == GAP_BITS * SYM_DIV - 1) begin
        mPhase = 0; mCyc = 0;
        mPtr = (mGrant + 1) % NUM_REQ;
      end else begin
        mCyc++;
      end
    end
    if (rst) begin
      mPhase = 0; mCyc = 0; mGrant = 0; mPtr = 0; mLast = 1'b0;
    end

    checkOutput("mod_data",   64'(bus.mod_data),   64'(eData));
    checkOutput("mod_enable", 64'(bus.mod_enable), 64'(eEn));
    checkOutput("busy",       64'(bus.busy),       64'(eBusy));
    checkOutput("grant_id",   64'(bus.grant_id),   64'(eGrant));
    checkOutput("req_ready",  64'(bus.req_ready),  64'(eReady));
    checkOutput("underrun",   64'(bus.underrun),   64'(eUnder));
  end

  initial begin
    int c;
    clearMon();

    // Reset held three cycles with both requesters asserting valid.
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_busy",      64'(bus.busy),       64'd0);
    checkOutput("rst_enable",    64'(bus.mod_enable), 64'd0);
    checkOutput("rst_ready",     64'(bus.req_ready),  64'd0);
    checkOutput("rst_grant",     64'(bus.grant_id),   64'd0);
    $display("[TB] reset phase done");

    // Single one-byte frame from requester 0.
    clearMon();
    forceValid = 1'b0;
    applyStimulus(0, 1'b1, 8'h3C);
    rst = 1'b0;
    waitFrames(1, 80, "single_done");
    checkOutput("single_en_cycles", 64'(enCount), 64'd32);
    checkOutput("single_ready0",    64'(rdyCnt0), 64'd1);
    checkOutput("single_ready1",    64'(rdyCnt1), 64'd0);
    checkOutput("single_bits",      stream[15:0], 64'hA53C);
    checkOutput("single_grant",     64'(logAt(grantLog, 0)), 64'd0);

    // Two back-to-back bytes from requester 1.
    clearMon();
    applyStimulus(1, 1'b0, 8'h01);
    applyStimulus(1, 1'b1, 8'hFF);
    waitFrames(1, 120, "multi_done");
    checkOutput("multi_en_cycles", 64'(enCount), 64'd48);
    checkOutput("multi_ready1",    64'(rdyCnt1), 64'd2);
    checkOutput("multi_ready0",    64'(rdyCnt0), 64'd0);
    checkOutput("multi_rdy_pos0",  64'(logAt(rdyPos, 0)), 64'd15);
    checkOutput("multi_rdy_pos1",  64'(logAt(rdyPos, 1)), 64'd31);
    checkOutput("multi_bits",      stream[23:0], 64'hA501FF);
    checkOutput("multi_grant",     64'(logAt(grantLog, 0)), 64'd1);

    // Both requesters pending: order must alternate 0, 1, 0.
    clearMon();
    applyStimulus(0, 1'b1, 8'hC1);
    applyStimulus(0, 1'b1, 8'hC2);
    applyStimulus(1, 1'b1, 8'hD1);
    waitFrames(3, 200, "rr_done");
    checkOutput("rr_grant0",   64'(logAt(grantLog, 0)), 64'd0);
    checkOutput("rr_grant1",   64'(logAt(grantLog, 1)), 64'd1);
    checkOutput("rr_grant2",   64'(logAt(grantLog, 2)), 64'd0);
    checkOutput("rr_ready0",   64'(rdyCnt0), 64'd2);
    checkOutput("rr_ready1",   64'(rdyCnt1), 64'd1);
    checkOutput("rr_en_cycles", 64'(enCount), 64'd96);

    // Requester 0 supplies one non-last byte and then goes quiet.
    clearMon();
    applyStimulus(0, 1'b0, 8'h55);
    waitFrames(1, 120, "under_done");
    checkOutput("under_count",     64'(undCnt), 64'd1);
    checkOutput("under_pos",       64'(logAt(undPos, 0)), 64'd31);
    checkOutput("under_en_cycles", 64'(enCount), 64'd32);
    checkOutput("under_ready0",    64'(rdyCnt0), 64'd1);
    checkOutput("under_bits",      stream[15:0], 64'hA555);

    // Reset in the middle of a payload byte, then check the pointer restarted at 0.
    clearMon();
    applyStimulus(0, 1'b0, 8'h11);
    applyStimulus(0, 1'b1, 8'h22);
    c = 0;
    while (enCount < 20 && c < 100) begin
      @(posedge clk); #2;
      c++;
    end
    checkOutput("midrst_reached", 64'(enCount >= 20), 64'd1);
    rst = 1'b1;
    @(posedge clk); #2;
    checkOutput("midrst_busy",   64'(bus.busy),       64'd0);
    checkOutput("midrst_enable", 64'(bus.mod_enable), 64'd0);
    checkOutput("midrst_data",   64'(bus.mod_data),   64'd0);
    clearMon();
    applyStimulus(1, 1'b1, 8'h88);
    rst = 1'b0;
    waitFrames(2, 200, "midrst_done");
    checkOutput("midrst_grant0", 64'(logAt(grantLog, 0)), 64'd0);
    checkOutput("midrst_grant1", 64'(logAt(grantLog, 1)), 64'd1);

    @(posedge clk); #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
